// File: rtl/pos_cell_buffer.sv
// pos_cell_buffer
//   Position store for one cell: a simple-dual-port RAM of {posz,posy,posx}
//   words plus a hardware-managed particle count. Particles live at
//   addresses 1..count; address 0 is reserved and reads back the count.
//
//   Write side (one RAM write per cycle, priority clear > wr_en > append):
//     clear                        empty the cell (count := 0, RAM untouched)
//     wr_en/wr_addr/wr_data        overwrite particle 1..count (motion update)
//     app_valid/app_data/app_ready append at count+1
//   Read side (2-cycle latency, address reg + output reg):
//     rd_en/rd_addr/rd_ready       random read, only while the FSM is idle
//     stream_start/stream_busy     burst every resident particle 1..count
//     rd_data/rd_valid/rd_last     read or stream data; rd_last ends a burst
//   Status:
//     count, full (count == DEPTH-1)
//
//   Optional build macro POS_CELL_OVERFLOW_FLAG_EN adds a sticky 'overflow'
//   output, set when an append is presented while full and cleared by rst
//   or clear. Without the macro, appends while full are only held off.
module pos_cell_buffer #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  app_valid,
  input  logic [DATA_WIDTH-1:0] app_data,
  output logic                  app_ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  stream_start,
  output logic                  stream_busy,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  full
`ifdef POS_CELL_OVERFLOW_FLAG_EN
  ,
  output logic                  overflow
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FULL_CNT = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] s_idx;
  logic [ADDR_WIDTH-1:0] s_len;

  logic                  vld_p0;
  logic                  last_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  vld_p1;
  logic                  last_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  logic                  wr_ok;
  logic                  app_fire;
  logic                  start_ok;
  logic                  abort;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign full        = (count == FULL_CNT);
  assign app_ready   = !full && !wr_en && !clear && (state == IDLE) && !rst;
  assign rd_ready    = (state == IDLE);
  assign stream_busy = (state != IDLE);

  assign rd_valid = vld_p1;
  assign rd_last  = last_p1;
  assign rd_data  = data_p1;

  // Overwrites outside 1..count are dropped; clear suppresses every write.
  assign wr_ok    = wr_en && !clear && (wr_addr != '0) && (wr_addr <= count);
  assign app_fire = app_valid && app_ready;
  assign start_ok = stream_start && (count != '0) && !clear;
  // A clear during a burst stops issuing; whatever is already in p0 becomes
  // the final word of the burst.
  assign abort    = (state == STREAM) && clear;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (wr_ok) begin
      mem_we = 1'b1;
    end else if (app_fire) begin
      mem_we    = 1'b1;
      mem_waddr = count + 1'b1;
      mem_wdata = app_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (app_fire) begin
      count <= count + 1'b1;
    end
  end

  // Stage p0: read address issue (random read in IDLE, burst index in STREAM)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_idx   <= '0;
      s_len   <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_en) begin
            vld_p0 <= 1'b1;
          end
          if (start_ok) begin
            state <= STREAM;
            s_idx <= ADDR_WIDTH'(1);
            s_len <= count;
          end
        end
        STREAM: begin
          if (clear) begin
            state <= DRAIN;
          end else begin
            vld_p0  <= 1'b1;
            last_p0 <= (s_idx == s_len);
            s_idx   <= s_idx + 1'b1;
            if (s_idx == s_len) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // p1 empties on this same edge, so only p0 needs to be clear.
          if (!vld_p0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      addr_p0 <= rd_addr;
    end else begin
      addr_p0 <= s_idx;
    end
  end

  // Stage p1: RAM output register; address 0 returns the count instead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && (last_p0 || abort);
      if (vld_p0) begin
        if (addr_p0 == '0) begin
          data_p1 <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, count};
        end else begin
          data_p1 <= mem[addr_p0];
        end
      end
    end
  end

`ifdef POS_CELL_OVERFLOW_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (app_valid && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pos_cell_buffer.sv
module tb_pos_cell_buffer;
  localparam int DW    = 96;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          app_valid = 1'b0;
  logic [DW-1:0] app_data = '0;
  logic          app_ready;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          stream_start = 1'b0;
  logic          stream_busy;
  logic [AW-1:0] count;
  logic          full;
`ifdef POS_CELL_OVERFLOW_FLAG_EN
  logic          overflow;
`endif

  pos_cell_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .app_valid(app_valid), .app_data(app_data), .app_ready(app_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .stream_start(stream_start), .stream_busy(stream_busy),
    .count(count), .full(full)
`ifdef POS_CELL_OVERFLOW_FLAG_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          clr;
    logic          av;
    logic [DW-1:0] ad;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ss;
  } stim_t;

  // Expected output word and the edge after which it must be visible.
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            vis;
  } exp_t;

  // Read request whose RAM lookup happens at edge 'due'.
  typedef struct {
    int   addr;
    logic last;
    int   due;
  } rd_t;

  exp_t          expq[$];
  rd_t           pend[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            m_count = 0;
  int            m_mode  = 0;   // 0 idle, 1 bursting, 2 finishing
  int            m_idx, m_len, m_end;
  logic          m_ovf = 1'b0;

  int   e_count = 0;
  logic e_busy = 1'b0;
  logic e_full = 1'b0;
  logic e_ovf  = 1'b0;
  bit   chk_on = 1'b0;

  function automatic logic [DW-1:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of stimulus and predict what the following edge does.
  task automatic step(input stim_t s);
    int   e;
    bit   busy;
    bit   ardy;
    rd_t  r;
    exp_t x;
    @(negedge clk);
    clear = s.clr; app_valid = s.av; app_data = s.ad;
    wr_en = s.we; wr_addr = s.wa; wr_data = s.wd;
    rd_en = s.re; rd_addr = s.ra; stream_start = s.ss;
    #1;
    e    = cyc + 1;
    busy = (m_mode != 0);
    ardy = (m_count != DEPTH - 1) && !s.we && !s.clr && !busy;
    chk("app_ready", app_ready, ardy);
    chk("rd_ready", rd_ready, !busy);

    if (m_mode == 1) begin
      if (s.clr) begin
        foreach (pend[i]) pend[i].last = 1'b1;
        m_mode = 2;
        m_end  = e + 1;
      end else begin
        r.addr = m_idx; r.last = (m_idx == m_len); r.due = e + 1;
        pend.push_back(r);
        if (m_idx == m_len) begin
          m_mode = 2;
          m_end  = e + 2;
        end
        m_idx++;
      end
    end else if (m_mode == 2) begin
      if (e == m_end) m_mode = 0;
    end else begin
      if (s.re) begin
        r.addr = int'(s.ra); r.last = 1'b0; r.due = e + 1;
        pend.push_back(r);
      end
      if (s.ss && m_count > 0 && !s.clr) begin
        m_mode = 1; m_idx = 1; m_len = m_count;
      end
    end

    // Lookups at this edge see the memory as it was before this edge's write.
    while (pend.size() > 0 && pend[0].due == e) begin
      r = pend.pop_front();
      x.data = (r.addr == 0) ? DW'(m_count) : m_mem[r.addr];
      x.last = r.last;
      x.vis  = e;
      expq.push_back(x);
    end

    m_ovf = s.clr ? 1'b0 : (m_ovf | (s.av && m_count == DEPTH - 1));
    if (s.clr) begin
      m_count = 0;
    end else if (s.we) begin
      if (s.wa != 0 && int'(s.wa) <= m_count) m_mem[s.wa] = s.wd;
    end else if (s.av && ardy) begin
      m_count++;
      m_mem[m_count] = s.ad;
    end

    e_count = m_count;
    e_busy  = (m_mode != 0);
    e_full  = (m_count == DEPTH - 1);
    e_ovf   = m_ovf;
  endtask

  task automatic idle(input int n);
    stim_t s;
    s = '0;
    repeat (n) step(s);
  endtask

  task automatic app(input logic [DW-1:0] d);
    stim_t s;
    s = '0; s.av = 1'b1; s.ad = d;
    step(s);
  endtask

  // Monitor: compares every DUT output word against the scoreboard.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (chk_on) begin
      if (rd_valid) begin
        if (expq.size() == 0) begin
          chk("rd_valid_unexpected", rd_valid, 1'b0);
        end else begin
          x = expq.pop_front();
          chk("rd_data", rd_data, x.data);
          chk("rd_last", rd_last, x.last);
          chk("rd_latency_edge", cyc, x.vis);
        end
      end else if (expq.size() > 0 && expq[0].vis <= cyc) begin
        chk("rd_valid_missing", rd_valid, 1'b1);
        void'(expq.pop_front());
      end
      chk("count", count, e_count);
      chk("full", full, e_full);
      chk("stream_busy", stream_busy, e_busy);
`ifdef POS_CELL_OVERFLOW_FLAG_EN
      chk("overflow", overflow, e_ovf);
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    logic [DW-1:0] a, b, c, d, f;
    a = rnd96(); b = rnd96(); c = rnd96(); d = rnd96(); f = rnd96();

    // Reset state, with an append presented during reset.
    app_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_app_ready", app_ready, 1'b0);
    chk("rst_count", count, '0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last", rd_last, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_stream_busy", stream_busy, 1'b0);
    app_valid = 1'b0;
    rst = 1'b0;
    chk_on = 1'b1;

    // Append A,B,C; read count (address 0) and index 2.
    app(a); app(b); app(c);
    s = '0; s.re = 1'b1; s.ra = 8'd0; step(s);
    s.ra = 8'd2; step(s);
    idle(3);

    // Burst of 3.
    s = '0; s.ss = 1'b1; step(s);
    idle(6);

    // Overwrite concurrent with append, then append lands at index 4.
    s = '0; s.we = 1'b1; s.wa = 8'd2; s.wd = d; s.av = 1'b1; s.ad = f; step(s);
    app(f);
    s = '0; s.we = 1'b1; s.wa = 8'd7; s.wd = rnd96(); step(s);
    s = '0; s.ss = 1'b1; step(s);
    idle(7);

    // Fill to full, push against full, then clear.
    while (m_count < DEPTH - 1) app(rnd96());
    repeat (3) app(rnd96());
    idle(2);
    s = '0; s.re = 1'b1; s.ra = 8'd255; step(s);
    idle(3);
    s = '0; s.clr = 1'b1; step(s);
    idle(2);

    // Clear after two issues of a 5-word burst.
    repeat (5) app(rnd96());
    s = '0; s.ss = 1'b1; step(s);
    idle(2);
    s = '0; s.clr = 1'b1; step(s);
    idle(5);

    // Reset in the middle of a burst.
    repeat (5) app(rnd96());
    s = '0; s.ss = 1'b1; step(s);
    idle(2);
    @(negedge clk);
    chk_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_rd_valid", rd_valid, 1'b0);
    chk("midrst_count", count, '0);
    chk("midrst_stream_busy", stream_busy, 1'b0);
    chk("midrst_rd_data", rd_data, '0);
    pend.delete(); expq.delete();
    m_count = 0; m_mode = 0; m_ovf = 1'b0;
    e_count = 0; e_busy = 1'b0; e_full = 1'b0; e_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    s = '0; s.ss = 1'b1; step(s);
    idle(4);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.clr = ($urandom_range(0, 99) < 2);
      s.av  = 1'($urandom_range(0, 1));
      s.ad  = rnd96();
      s.we  = ($urandom_range(0, 4) == 0);
      s.wa  = AW'($urandom_range(0, m_count + 2));
      s.wd  = rnd96();
      s.re  = ($urandom_range(0, 2) == 0);
      s.ra  = AW'($urandom_range(0, m_count));
      s.ss  = ($urandom_range(0, 19) == 0);
      step(s);
    end
    idle(6);
    chk("scoreboard_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
